coin_change_dispenser: RTL and testbench
========================================

Name: coin_change_dispenser

Overview:
Dispenses change as 500- and 100-colón coins. This is the output counterpart to the coin-counting front end.
- The front end reports the change owed as a count of 100-colón units.
- This block plans a greedy split and checks that its coin stock can cover it. It then drives hopper solenoids one coin at a time.
- Coin stock is tracked internally and refilled by service logic.

Parameters:
AMOUNT_W, 8, width of change_amount and remaining (units of 100 colones)
INV_W, 6, width of each stock counter
PULSE_CYCLES, 4, cycles a dispense line is held high per coin (>=1)
GAP_CYCLES, 4, low cycles after each pulse before the next coin (>=1)
TIMEOUT_CYCLES, 64, sensor wait limit (used only with COIN_SENSE_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  request to dispense change_amount; sampled only in IDLE
change_amount  in  AMOUNT_W  change owed, in 100-colón units
refill  in  1  add refill_500/refill_100 to stock; honoured only in IDLE
refill_500  in  INV_W  number of 500 coins added on refill
refill_100  in  INV_W  number of 100 coins added on refill
coin_sensed  in  1  hopper exit sensor pulse (ignored without COIN_SENSE_EN)
dispense_500  out  1  500 hopper solenoid
dispense_100  out  1  100 hopper solenoid
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when change is fully paid
error  out  1  one-cycle pulse when the request cannot be paid, or on fault
remaining  out  AMOUNT_W  units still owed in the current transaction
stock_500  out  INV_W  500 coins in hopper
stock_100  out  INV_W  100 coins in hopper

Behaviour:
- Reset values:
  - All outputs 0, both stocks 0, FSM in IDLE.
  - Reset mid-pulse drops the dispense lines at that same edge.
- States: IDLE, PLAN, PULSE, GAP, DONE, ERROR.
- IDLE:
  - refill=1 adds both refill values to stock, saturating at 2^INV_W-1.
  - start=1 moves to PLAN. It latches plan_rem=change_amount and remaining=change_amount, and clears n500.
  - If refill and start arrive in the same cycle, both are honoured; PLAN sees the updated stock.
  - refill outside IDLE is ignored.
- PLAN (one cycle per step):
  - If plan_rem>=5 and n500<stock_500: plan_rem-=5, n500+=1, stay in PLAN.
  - Otherwise, if plan_rem<=stock_100: set n100=plan_rem.
    - If n500+n100==0, go to DONE.
    - Else go to PULSE with the 500 coin selected if n500>0, otherwise the 100 coin.
  - Otherwise go to ERROR.
- PULSE:
  - The selected dispense line is high for exactly PULSE_CYCLES cycles. Never both lines at once.
  - On the last pulse cycle: the selected stock decrements by 1, remaining decrements by 5 or 1, and the matching n-counter decrements.
  - Then go to GAP.
- GAP:
  - Both lines are low for GAP_CYCLES cycles.
  - Then go to PULSE (all 500 coins before any 100 coin), or to DONE when both n-counters are 0.
- DONE: done=1 for one cycle, remaining=0, then IDLE.
- ERROR: error=1 for one cycle, then IDLE. Stocks are unchanged; remaining keeps the requested amount.
- start held high across DONE or ERROR starts a new transaction only after the return to IDLE.
- Arithmetic:
  - Stock decrements never underflow; PLAN guarantees enough coins.
  - The remaining decrement is exact.
  - change_amount=0 gives done on the third cycle after start (IDLE→PLAN→DONE) with no pulses.

Optional Feature:
Macro COIN_SENSE_EN.
- Defined: GAP is replaced by a wait that leaves when coin_sensed=1, or after a minimum of GAP_CYCLES, whichever is later.
  - If coin_sensed stays low for TIMEOUT_CYCLES from the end of the pulse, go to ERROR.
  - On that fault the stock and remaining decrements already applied stay applied.
- Not defined: coin_sensed is unused and GAP is purely timed.

Test Plan:
1. Reset; refill 500=3, 100=10; start amount=7.
   -> one 4-cycle dispense_500 pulse, then two dispense_100 pulses, each followed by a 4-cycle gap; done pulse.
   -> stock_500=2, stock_100=8, remaining=0.
2. Stock 500=1, 100=4; start amount=12.
   -> PLAN allocates 1×500 and needs 7×100 > 4 -> error pulse, no dispense activity, stocks still 1/4, remaining=12.
3. Stock 500=1, 100=10; start amount=10.
   -> one 500 pulse, then five 100 pulses; stock_500=0, stock_100=5; done.
4. Start amount=0 -> done exactly 2 cycles after the start cycle, busy high for 2 cycles, no pulses.
5. Amount=7 in progress; assert reset during the second pulse.
   -> both dispense lines low at that edge; busy=0, stocks=0, remaining=0; an IDLE refill afterwards works normally.
6. With COIN_SENSE_EN: amount=1, coin_sensed never asserted.
   -> error exactly TIMEOUT_CYCLES after the pulse ends; stock_100 already decremented.
   -> A second run with coin_sensed pulsed 2 cycles after the pulse leaves wait after GAP_CYCLES; done.

Source files
------------

// File: rtl/coin_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : coin_change_dispenser
// Purpose  : Pays out change in 500- and 100-colon coins. A request for
//            change_amount units (of 100 colones) is split greedily into
//            500 coins first, then 100 coins, checked against the internal
//            coin stock, and paid one coin at a time by pulsing the hopper
//            solenoids. Stock is topped up by service logic via refill.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            start, change_amount  - payout request (accepted in IDLE only)
//            refill, refill_500/100- stock top-up (accepted in IDLE only)
//            coin_sensed           - hopper exit sensor (COIN_SENSE_EN only)
//            dispense_500/100      - hopper solenoids, never both high
//            busy, done, error     - status; done/error are 1-cycle pulses
//            remaining             - units still owed this transaction
//            stock_500/100         - coins currently in each hopper
// Options  : `define COIN_SENSE_EN to wait for the exit sensor after each
//            coin (with timeout) instead of a purely timed gap.
// Revision : 1.0 - initial release
// ============================================================================
module coin_change_dispenser #(
  parameter int AMOUNT_W       = 8,
  parameter int INV_W          = 6,
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [AMOUNT_W-1:0] change_amount,
  input  logic                refill,
  input  logic [INV_W-1:0]    refill_500,
  input  logic [INV_W-1:0]    refill_100,
  input  logic                coin_sensed,
  output logic                dispense_500,
  output logic                dispense_100,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [AMOUNT_W-1:0] remaining,
  output logic [INV_W-1:0]    stock_500,
  output logic [INV_W-1:0]    stock_100
);

  // Common width for comparing coin counts (AMOUNT_W) against stock (INV_W).
  localparam int CMP_W = (AMOUNT_W > INV_W) ? AMOUNT_W : INV_W;
  // One timer serves pulse, gap and sensor timeout.
  localparam int T_MAX0 = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int T_MAX  = (T_MAX0 > TIMEOUT_CYCLES) ? T_MAX0 : TIMEOUT_CYCLES;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [AMOUNT_W-1:0] C_FIVE     = AMOUNT_W'(5);
  localparam logic [AMOUNT_W-1:0] C_ONE_AMT  = AMOUNT_W'(1);
  localparam logic [INV_W-1:0]    C_ONE_INV  = INV_W'(1);
  localparam logic [TMR_W-1:0]    C_PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0]    C_GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0]    C_TMR_ONE    = TMR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAN  = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t              state_q,     state_d;
  logic [AMOUNT_W-1:0] plan_rem_q,  plan_rem_d;
  logic [AMOUNT_W-1:0] n500_q,      n500_d;
  logic [AMOUNT_W-1:0] n100_q,      n100_d;
  logic [AMOUNT_W-1:0] remaining_q, remaining_d;
  logic [INV_W-1:0]    stock_500_q, stock_500_d;
  logic [INV_W-1:0]    stock_100_q, stock_100_d;
  logic [TMR_W-1:0]    tmr_q,       tmr_d;
  logic                sel500_q,    sel500_d;

  logic gap_exit;     // leave the gap toward the next coin / DONE
  logic gap_timeout;  // sensor never reported the coin

  function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                                input logic [INV_W-1:0] b);
    logic [INV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[INV_W] ? {INV_W{1'b1}} : s[INV_W-1:0];
  endfunction

`ifdef COIN_SENSE_EN
  logic sensed_q, sensed_d;

  // The sensor may fire before the minimum gap has elapsed, so it is
  // remembered until the gap may end.
  always_comb begin
    sensed_d    = sensed_q;
    gap_exit    = 1'b0;
    gap_timeout = 1'b0;
    if (state_q == S_PULSE) begin
      sensed_d = 1'b0;
    end else if (state_q == S_GAP) begin
      sensed_d    = sensed_q | coin_sensed;
      gap_exit    = (sensed_q | coin_sensed) && (tmr_q >= C_GAP_LAST);
      gap_timeout = !gap_exit && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sensed_q <= 1'b0;
    else       sensed_q <= sensed_d;
  end
`else
  logic unused_coin_sensed;
  assign unused_coin_sensed = coin_sensed;

  always_comb begin
    gap_exit    = (state_q == S_GAP) && (tmr_q == C_GAP_LAST);
    gap_timeout = 1'b0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    plan_rem_d  = plan_rem_q;
    n500_d      = n500_q;
    n100_d      = n100_q;
    remaining_d = remaining_q;
    stock_500_d = stock_500_q;
    stock_100_d = stock_100_q;
    tmr_d       = tmr_q;
    sel500_d    = sel500_q;

    case (state_q)
      S_IDLE: begin
        if (refill) begin
          stock_500_d = sat_add(stock_500_q, refill_500);
          stock_100_d = sat_add(stock_100_q, refill_100);
        end
        if (start) begin
          plan_rem_d  = change_amount;
          remaining_d = change_amount;
          n500_d      = '0;
          state_d     = S_PLAN;
        end
      end

      // One 500 coin is allocated per cycle while both amount and stock allow.
      S_PLAN: begin
        if ((plan_rem_q >= C_FIVE) &&
            (CMP_W'(n500_q) < CMP_W'(stock_500_q))) begin
          plan_rem_d = plan_rem_q - C_FIVE;
          n500_d     = n500_q + C_ONE_AMT;
        end else if (CMP_W'(plan_rem_q) <= CMP_W'(stock_100_q)) begin
          n100_d = plan_rem_q;
          if ((n500_q == '0) && (plan_rem_q == '0)) begin
            remaining_d = '0;
            state_d     = S_DONE;
          end else begin
            sel500_d = (n500_q != '0);
            tmr_d    = '0;
            state_d  = S_PULSE;
          end
        end else begin
          state_d = S_ERROR;
        end
      end

      // Stock and remaining are booked on the last pulse cycle.
      S_PULSE: begin
        if (tmr_q == C_PULSE_LAST) begin
          if (sel500_q) begin
            stock_500_d = stock_500_q - C_ONE_INV;
            remaining_d = remaining_q - C_FIVE;
            n500_d      = n500_q - C_ONE_AMT;
          end else begin
            stock_100_d = stock_100_q - C_ONE_INV;
            remaining_d = remaining_q - C_ONE_AMT;
            n100_d      = n100_q - C_ONE_AMT;
          end
          tmr_d   = '0;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q + C_TMR_ONE;
        end
      end

      S_GAP: begin
        if (gap_exit) begin
          tmr_d = '0;
          if (n500_q != '0) begin
            sel500_d = 1'b1;
            state_d  = S_PULSE;
          end else if (n100_q != '0) begin
            sel500_d = 1'b0;
            state_d  = S_PULSE;
          end else begin
            remaining_d = '0;
            state_d     = S_DONE;
          end
        end else if (gap_timeout) begin
          state_d = S_ERROR;
        end else begin
          tmr_d = tmr_q + C_TMR_ONE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      plan_rem_q  <= '0;
      n500_q      <= '0;
      n100_q      <= '0;
      remaining_q <= '0;
      stock_500_q <= '0;
      stock_100_q <= '0;
      tmr_q       <= '0;
      sel500_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      plan_rem_q  <= plan_rem_d;
      n500_q      <= n500_d;
      n100_q      <= n100_d;
      remaining_q <= remaining_d;
      stock_500_q <= stock_500_d;
      stock_100_q <= stock_100_d;
      tmr_q       <= tmr_d;
      sel500_q    <= sel500_d;
    end
  end

  // Outputs decode registered state only, so reset drops them at its edge.
  assign dispense_500 = (state_q == S_PULSE) &&  sel500_q;
  assign dispense_100 = (state_q == S_PULSE) && !sel500_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign remaining    = remaining_q;
  assign stock_500    = stock_500_q;
  assign stock_100    = stock_100_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_change_dispenser
// Purpose  : Self-checking bench for coin_change_dispenser (default build).
//            Table of payout transactions with expected outcome, coin
//            counts, stock and remaining; plus hand-written sequences for
//            zero-amount latency, start held high, and reset mid-pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_change_dispenser;

  localparam int AMOUNT_W       = 8;
  localparam int INV_W          = 6;
  localparam int PULSE_CYCLES   = 4;
  localparam int GAP_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int WAIT_LIMIT     = 4000;

  logic                clk;
  logic                reset;
  logic                start;
  logic [AMOUNT_W-1:0] change_amount;
  logic                refill;
  logic [INV_W-1:0]    refill_500;
  logic [INV_W-1:0]    refill_100;
  logic                coin_sensed;
  logic                dispense_500;
  logic                dispense_100;
  logic                busy;
  logic                done;
  logic                error;
  logic [AMOUNT_W-1:0] remaining;
  logic [INV_W-1:0]    stock_500;
  logic [INV_W-1:0]    stock_100;

  coin_change_dispenser #(
    .AMOUNT_W      (AMOUNT_W),
    .INV_W         (INV_W),
    .PULSE_CYCLES  (PULSE_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .change_amount(change_amount),
    .refill       (refill),
    .refill_500   (refill_500),
    .refill_100   (refill_100),
    .coin_sensed  (coin_sensed),
    .dispense_500 (dispense_500),
    .dispense_100 (dispense_100),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .remaining    (remaining),
    .stock_500    (stock_500),
    .stock_100    (stock_100)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit do_reset;
    int r500;
    int r100;
    int amt;
    bit exp_ok;
    int exp_n500;
    int exp_n100;
    int exp_s500;
    int exp_s100;
    int exp_rem;
  } vec_t;

  typedef struct {
    bit ok;
    int n500;
    int n100;
    int s500;
    int s100;
    int rem;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[13];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, int r5, int r1, int amt, bit ok,
                              int n5, int n1, int s5, int s1, int rem);
    vec_t v;
    v.do_reset = rst; v.r500 = r5; v.r100 = r1; v.amt = amt; v.exp_ok = ok;
    v.exp_n500 = n5; v.exp_n100 = n1; v.exp_s500 = s5; v.exp_s100 = s1;
    v.exp_rem = rem;
    return v;
  endfunction

  // One transaction: optional reset, IDLE refill, start, then watch the
  // solenoids until done/error and compare against the scoreboard entry.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t g;
    int   cycles;
    int   p500, p100, hirun, lorun;
    int   bad_width, bad_gap, bad_both, bad_order;
    bit   prev_hi, cur_hi, seen_pulse, seen100, finished;
    string tag;
    tag = $sformatf("v%0d", idx);

    if (v.do_reset) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    refill     = 1'b1;
    refill_500 = INV_W'(v.r500);
    refill_100 = INV_W'(v.r100);
    @(negedge clk);
    refill = 1'b0;

    start         = 1'b1;
    change_amount = AMOUNT_W'(v.amt);
    e.ok = v.exp_ok; e.n500 = v.exp_n500; e.n100 = v.exp_n100;
    e.s500 = v.exp_s500; e.s100 = v.exp_s100; e.rem = v.exp_rem;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;

    cycles = 0; p500 = 0; p100 = 0; hirun = 0; lorun = 0;
    bad_width = 0; bad_gap = 0; bad_both = 0; bad_order = 0;
    prev_hi = 1'b0; seen_pulse = 1'b0; seen100 = 1'b0; finished = 1'b0;
    while (cycles < WAIT_LIMIT) begin
      cur_hi = dispense_500 | dispense_100;
      if (dispense_500 && dispense_100) bad_both++;
      if (cur_hi) begin
        if (!prev_hi) begin
          if (seen_pulse && lorun != GAP_CYCLES) bad_gap++;
          if (dispense_500) begin
            p500++;
            if (seen100) bad_order++;
          end else begin
            p100++;
            seen100 = 1'b1;
          end
          seen_pulse = 1'b1;
          hirun = 0;
        end
        hirun++;
        lorun = 0;
      end else begin
        if (prev_hi && hirun != PULSE_CYCLES) bad_width++;
        lorun++;
      end
      prev_hi = cur_hi;
      if (done || error) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end

    check({tag, "_finished"}, int'(finished), 1);
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 0, 1);
    end else begin
      g = sb_q.pop_front();
      check({tag, "_done"},       int'(done), int'(g.ok));
      check({tag, "_error"},      int'(error), int'(!g.ok));
      check({tag, "_busy"},       int'(busy), 1);
      check({tag, "_n500"},       p500, g.n500);
      check({tag, "_n100"},       p100, g.n100);
      check({tag, "_remaining"},  int'(remaining), g.rem);
      check({tag, "_stock500"},   int'(stock_500), g.s500);
      check({tag, "_stock100"},   int'(stock_100), g.s100);
      check({tag, "_pulse_width"}, bad_width, 0);
      check({tag, "_gap_width"},  bad_gap, 0);
      check({tag, "_both_lines"}, bad_both, 0);
      check({tag, "_coin_order"}, bad_order, 0);
    end
    @(negedge clk);
    check({tag, "_idle_busy"}, int'(busy), 0);
    check({tag, "_idle_pulse"}, int'(done | error), 0);
  endtask

  initial begin : main
    bit found;
    bit did_refill;

    reset = 1'b1; start = 1'b0; change_amount = '0; refill = 1'b0;
    refill_500 = '0; refill_100 = '0; coin_sensed = 1'b0;

    //             rst r500 r100 amt  ok n500 n100 s500 s100 rem
    vecs[0]  = mk(1,   3,  10,   7, 1,  1,   2,   2,   8,   0);
    vecs[1]  = mk(1,   1,   4,  12, 0,  0,   0,   1,   4,  12);
    vecs[2]  = mk(0,   0,   6,  10, 1,  1,   5,   0,   5,   0);
    vecs[3]  = mk(0,   0,   0,   0, 1,  0,   0,   0,   5,   0);
    vecs[4]  = mk(0,  63,  63,  20, 1,  4,   0,  59,  63,   0);
    vecs[5]  = mk(0,   0,   0, 255, 1, 51,   0,   8,  63,   0);
    vecs[6]  = mk(0,   0,   0,  13, 1,  2,   3,   6,  60,   0);
    vecs[7]  = mk(0,   0,   0,   4, 1,  0,   4,   6,  56,   0);
    vecs[8]  = mk(0,   0,   0,  64, 1,  6,  34,   0,  22,   0);
    vecs[9]  = mk(0,   0,   0,  23, 0,  0,   0,   0,  22,  23);
    vecs[10] = mk(0,   0,   0,  22, 1,  0,  22,   0,   0,   0);
    vecs[11] = mk(0,   1,   0,   5, 1,  1,   0,   0,   0,   0);
    vecs[12] = mk(0,   0,   0,   1, 0,  0,   0,   0,   0,   1);

    repeat (2) @(negedge clk);
    check("rst_busy",      int'(busy), 0);
    check("rst_done",      int'(done), 0);
    check("rst_error",     int'(error), 0);
    check("rst_disp",      int'(dispense_500 | dispense_100), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_stock500",  int'(stock_500), 0);
    check("rst_stock100",  int'(stock_100), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Zero amount with start held high: done 2 cycles after start, and a
    // new transaction only begins after passing through IDLE.
    start = 1'b1; change_amount = '0;
    @(negedge clk);
    check("z_plan_busy", int'(busy), 1);
    check("z_plan_done", int'(done), 0);
    @(negedge clk);
    check("z_done",      int'(done), 1);
    check("z_done_busy", int'(busy), 1);
    @(negedge clk);
    check("z_idle_busy", int'(busy), 0);
    check("z_idle_done", int'(done), 0);
    @(negedge clk);
    check("z_restart_busy", int'(busy), 1);
    start = 1'b0;
    @(negedge clk);
    check("z_done2", int'(done), 1);
    @(negedge clk);
    check("z_end_busy", int'(busy), 0);

    // Reset during the second coin (first 100 pulse) of a 7-unit payout;
    // a refill attempted mid-transaction must be ignored.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    refill = 1'b1; refill_500 = 6'd3; refill_100 = 6'd10;
    @(negedge clk);
    refill = 1'b0;
    start = 1'b1; change_amount = 8'd7;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0; did_refill = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      refill = 1'b0;
      if (dispense_100) begin
        found = 1'b1;
        break;
      end
      if (dispense_500 && !did_refill) begin
        refill = 1'b1; refill_500 = 6'd5; refill_100 = 6'd5;
        did_refill = 1'b1;
      end
    end
    check("r_second_pulse_seen", int'(found), 1);
    check("r_busy_refill_ignored500", int'(stock_500), 2);
    check("r_busy_refill_ignored100", int'(stock_100), 10);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("r_disp_at_edge", int'(dispense_500 | dispense_100), 0);
    @(negedge clk);
    check("r_busy",      int'(busy), 0);
    check("r_stock500",  int'(stock_500), 0);
    check("r_stock100",  int'(stock_100), 0);
    check("r_remaining", int'(remaining), 0);
    reset = 1'b0;
    refill = 1'b1; refill_500 = 6'd2; refill_100 = 6'd3;
    @(negedge clk);
    refill = 1'b0;
    check("r_refill500", int'(stock_500), 2);
    check("r_refill100", int'(stock_100), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
